// File: rtl/bus_pkg.sv
// Shared types and constants for the client-bus initiator and arbiter blocks.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } bus_state_t;

  localparam logic WR_NI_READ  = 1'b1;
  localparam logic WR_NI_WRITE = 1'b0;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Free-running wait counter with synchronous clear; expired flags the last
// permitted cycle (count = limit-1). A limit of zero never expires.
module bus_timeout_cnt #(
  parameter int TO_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [TO_WIDTH-1:0] limit,
  output logic                expired
);

  logic [TO_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + TO_WIDTH'(1);
    end
  end

  assign expired = (limit != '0) && (count_reg == limit - TO_WIDTH'(1));

endmodule

// File: rtl/bus_master_if.sv
// Client-bus initiator: accepts a local command, runs the rq/ack four-phase
// handshake toward a client and returns a one-cycle response strobe.
module bus_master_if
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = 16,
  parameter int TO_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_ni,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rq,
  input  logic                  ack,
  output logic                  wr_ni,
  output logic [DATA_WIDTH-1:0] dataW,
  input  logic [DATA_WIDTH-1:0] dataR
);

  bus_state_t            state_reg, state_next;
  logic                  rq_reg, rq_next;
  logic                  cmd_ready_reg, cmd_ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic                  abort_reg, abort_next;
  logic                  wr_ni_reg, wr_ni_next;
  logic [ADDR_WIDTH-1:0] address_reg, address_next;
  logic [DATA_WIDTH-1:0] dataw_reg, dataw_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic                  cnt_clear, cnt_enable, cnt_expired;

  bus_timeout_cnt #(.TO_WIDTH(TO_WIDTH)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (TO_WIDTH'(TIMEOUT)),
    .expired (cnt_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rq_reg        <= 1'b0;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      abort_reg     <= 1'b0;
      wr_ni_reg     <= 1'b0;
      address_reg   <= '0;
      dataw_reg     <= '0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rq_reg        <= rq_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      abort_reg     <= abort_next;
      wr_ni_reg     <= wr_ni_next;
      address_reg   <= address_next;
      dataw_reg     <= dataw_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rq_next        = rq_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    abort_next     = abort_reg;
    wr_ni_next     = wr_ni_reg;
    address_next   = address_reg;
    dataw_next     = dataw_reg;
    rsp_data_next  = rsp_data_reg;
    cnt_clear      = 1'b0;
    cnt_enable     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          address_next = cmd_addr;
          dataw_next   = cmd_data;
          wr_ni_next   = cmd_wr_ni;
          rq_next      = 1'b1;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          if (wr_ni_reg == WR_NI_READ) begin
            rsp_data_next = dataR;
          end
          rq_next    = 1'b0;
          state_next = REL;
        end else begin
          cnt_enable = 1'b1;
          if (cnt_expired) begin
            rq_next    = 1'b0;
            abort_next = 1'b1;
            state_next = REL;
          end
        end
      end
      REL: begin
        // No timeout here: the client must release ack before we move on.
        if (!ack) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = abort_reg;
          abort_next     = 1'b0;
          cnt_clear      = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    cmd_ready_next = (state_next == IDLE) && !ack;
  end

  assign cmd_ready = cmd_ready_reg;
  assign rq        = rq_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rsp_data_reg;
  assign address   = address_reg;
  assign wr_ni     = wr_ni_reg;
  assign dataW     = dataw_reg;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: a responder client, a transaction-level
// timing model checked every cycle, and literal latency/data expectations.
module tb_bus_master_if;
  import bus_pkg::*;

  localparam int TIMEOUT = 16;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready, cmd_wr_ni;
  logic [3:0] cmd_addr, address;
  logic [7:0] cmd_data, rsp_data, dataW, dataR;
  logic       rsp_valid, rsp_err, rq, ack, wr_ni;

  logic client_never, force_mode, ack_force;
  int   checks = 0;
  int   failures = 0;

  bus_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TIMEOUT), .TO_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_ni(cmd_wr_ni),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .address(address), .rq(rq), .ack(ack), .wr_ni(wr_ni),
    .dataW(dataW), .dataR(dataR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Client: acks one cycle after seeing rq, releases one cycle after rq falls.
  initial begin : client
    logic rq_s;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      rq_s = rq;
      @(posedge clk);
      #1;
      if (force_mode)        ack = ack_force;
      else if (client_never) ack = 1'b0;
      else                   ack = rq_s;
    end
  end

  // Transaction-level model: fixed latencies from acceptance for this client.
  int         cyc, m_acc, m_rq_end, m_rsp_cyc;
  logic       m_busy, m_ready, m_err, m_to, m_wr;
  logic [3:0] m_addr;
  logic [7:0] m_dw, m_data;

  always @(posedge clk or negedge reset) begin : model
    int   nc;
    logic acc;
    if (!reset) begin
      cyc = 0; m_acc = 0; m_rq_end = 0; m_rsp_cyc = 0;
      m_busy = 0; m_ready = 0; m_err = 0; m_to = 0; m_wr = 0;
      m_addr = '0; m_dw = '0; m_data = '0;
    end else begin
      nc  = cyc + 1;
      acc = cmd_valid && m_ready;
      if (m_busy && !m_to && m_wr == WR_NI_READ && cyc == m_acc + 1) m_data = dataR;
      if (acc) begin
        m_busy    = 1'b1;
        m_acc     = nc;
        m_addr    = cmd_addr;
        m_dw      = cmd_data;
        m_wr      = cmd_wr_ni;
        m_to      = client_never;
        m_err     = client_never;
        m_rq_end  = nc + (client_never ? TIMEOUT - 1 : 1);
        m_rsp_cyc = nc + (client_never ? TIMEOUT + 1 : 4);
      end
      m_ready = !acc && (!m_busy || nc >= m_rsp_cyc) && !ack;
      cyc = nc;
    end
  end

  always @(negedge clk) begin : compare
    logic exp_rq, exp_rv;
    if (reset) begin
      exp_rq = m_busy && cyc >= m_acc && cyc <= m_rq_end;
      exp_rv = m_busy && cyc == m_rsp_cyc;
      chk("m_rq", rq, exp_rq);
      chk("m_rsp_valid", rsp_valid, exp_rv);
      chk("m_cmd_ready", cmd_ready, m_ready);
      if (exp_rv) begin
        chk("m_rsp_err", rsp_err, m_err);
        chk("m_rsp_data", rsp_data, m_data);
      end
      if (exp_rq) begin
        chk("m_address", address, m_addr);
        chk("m_dataW", dataW, m_dw);
        chk("m_wr_ni", wr_ni, m_wr);
      end
    end
  end

  // Issue one command in the current cycle and measure latency from there.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [7:0] d,
                         input string tag, input int exp_lat, input int exp_rqlen,
                         input logic exp_err, input logic [7:0] exp_data);
    int n, rqn;
    logic acc, seen, err_s;
    logic [7:0] data_s;
    cmd_valid = 1'b1; cmd_wr_ni = wr; cmd_addr = a; cmd_data = d;
    n = 0; rqn = 0; seen = 0; err_s = 0; data_s = '0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (rq) rqn++;
      if (rsp_valid) begin
        seen = 1'b1; err_s = rsp_err; data_s = rsp_data;
      end
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_rq_cycles"}, rqn, exp_rqlen);
    chk({tag, "_rsp_err"}, err_s, exp_err);
    chk({tag, "_rsp_data"}, data_s, exp_data);
    $display("txn %s wr_ni=%0b addr=%0h latency=%0d rq_cycles=%0d err=%0b data=%0h",
             tag, wr, a, n, rqn, err_s, data_s);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1);
  end

  initial begin : stim
    int n, rvn, rqn;
    reset = 1'b0; cmd_valid = 1'b0; cmd_wr_ni = 1'b0; cmd_addr = '0; cmd_data = '0;
    dataR = '0; client_never = 1'b0; force_mode = 1'b0; ack_force = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rq", rq, 0);           chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0); chk("rst_address", address, 0);
    chk("rst_dataW", dataW, 0);     chk("rst_rsp_data", rsp_data, 0);
    chk("rst_wr_ni", wr_ni, 0);     chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_first_edge", cmd_ready, 1);
    @(posedge clk);
    #1;

    run_cmd(WR_NI_WRITE, 4'h3, 8'hA5, "write", 6, 2, 1'b0, 8'h00);
    dataR = 8'h5E;
    run_cmd(WR_NI_READ, 4'hC, 8'h00, "read", 6, 2, 1'b0, 8'h5E);
    client_never = 1'b1;
    run_cmd(WR_NI_READ, 4'h7, 8'h00, "timeout", TIMEOUT + 3, TIMEOUT, 1'b1, 8'h5E);
    client_never = 1'b0;
    run_cmd(WR_NI_WRITE, 4'hA, 8'h3C, "after_timeout", 6, 2, 1'b0, 8'h5E);

    // Back-to-back reads with cmd_valid held high.
    dataR = 8'h11; cmd_valid = 1'b1; cmd_wr_ni = WR_NI_READ; cmd_addr = 4'h1; cmd_data = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 64);
    chk("b2b_first_latency", n, 6);
    chk("b2b_first_data", rsp_data, 8'h11);
    chk("b2b_ready_at_rsp", cmd_ready, 1);
    chk("b2b_rq_low_at_rsp", rq, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; dataR = 8'h22;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 64);
    chk("b2b_second_latency", n, 5);
    chk("b2b_second_data", rsp_data, 8'h22);
    $display("txn b2b second latency=%0d data=%0h", n, rsp_data);
    @(posedge clk);
    #1;

    // Stale ack while idle blocks acceptance.
    @(negedge clk);
    force_mode = 1'b1; ack_force = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_wr_ni = WR_NI_WRITE; cmd_addr = 4'h5; cmd_data = 8'h96;
    repeat (4) begin
      @(negedge clk);
      chk("stale_cmd_ready", cmd_ready, 0);
      chk("stale_rq", rq, 0);
    end
    force_mode = 1'b0;
    run_cmd(WR_NI_WRITE, 4'h5, 8'h96, "stale_ack", 7, 2, 1'b0, 8'h22);

    // Reset while rq is high.
    client_never = 1'b1;
    cmd_valid = 1'b1; cmd_wr_ni = WR_NI_READ; cmd_addr = 4'h9; cmd_data = 8'h00;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rq_high", rq, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rq", rq, 0);             chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0); chk("mid_rst_address", address, 0);
    chk("mid_rst_dataW", dataW, 0);       chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_wr_ni", wr_ni, 0);       chk("mid_rst_rsp_err", rsp_err, 0);
    $display("txn reset_mid_req rq=%0b rsp_valid=%0b", rq, rsp_valid);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    client_never = 1'b0;
    rvn = 0; rqn = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) rvn++;
      if (rq) rqn++;
    end
    chk("post_rst_no_rsp", rvn, 0);
    chk("post_rst_no_rq", rqn, 0);
    @(posedge clk);
    #1;
    dataR = 8'hC3;
    run_cmd(WR_NI_READ, 4'hE, 8'h00, "post_reset_read", 6, 2, 1'b0, 8'hC3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Initiator end of the client bus rq/ack handshake. A local command port (valid/ready) feeds it; it drives address, rq, wr_ni and dataW toward a client and waits for ack.
- On a read it captures dataR and returns it on a one-cycle response strobe.
- Sits between an arbiter grant path and a client; used as the RTL initiator against the client bench model.

Parameters:
- DATA_WIDTH, 8, width of dataW/dataR/cmd_data/rsp_data
- ADDR_WIDTH, 4, width of address/cmd_addr
- TIMEOUT, 16, max cycles in REQ without ack before abort; 0 disables the timeout
- TO_WIDTH, 5, timeout counter width; must hold TIMEOUT

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  local command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_wr_ni  input  1  1 = read, 0 = write
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_data  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle pulse, transaction complete
- rsp_err  output  1  valid with rsp_valid; 1 = timeout abort
- rsp_data  output  DATA_WIDTH  read data, valid with rsp_valid
- address  output  ADDR_WIDTH  bus address
- rq  output  1  bus request
- ack  input  1  client acknowledge
- wr_ni  output  1  1 = read, 0 = write
- dataW  output  DATA_WIDTH  bus write data
- dataR  input  DATA_WIDTH  bus read data

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state IDLE; rq, rsp_valid, rsp_err, cmd_ready=0; address, dataW, rsp_data=0; wr_ni=0; timeout counter=0.
- cmd_ready is 1 only in IDLE while ack=0. cmd_ready=0 during the first clk after reset release, then 1.
- FSM states: IDLE, REQ, REL.
- IDLE:
  - On cmd_valid & cmd_ready, register cmd_addr→address, cmd_data→dataW, cmd_wr_ni→wr_ni.
  - Set rq=1 and go to REQ. rq is high on the cycle after acceptance.
  - cmd_ready drops the same edge.
- REQ:
  - address, wr_ni and dataW are held stable.
  - If ack is sampled 1: if wr_ni=1, capture dataR into rsp_data (a write leaves rsp_data unchanged); rq←0; go to REL.
  - Otherwise increment the counter. If TIMEOUT≠0 and counter = TIMEOUT-1: rq←0, set the sticky abort flag, go to REL.
- REL:
  - Wait for ack sampled 0. Then pulse rsp_valid for 1 cycle, with rsp_err = abort flag; clear the flag and counter; go to IDLE.
  - REL has no timeout: a client that never drops ack stalls the block.
- Latency against a client that acks 1 cycle after rq and drops ack 1 cycle after rq falls:
  - accept at edge T; rq high T+1; ack high T+2.
  - Sampled at T+3: rq low, capture. Ack low at T+4, sampled T+5.
  - rsp_valid high for T+5..T+6; cmd_ready high again from T+5.
- Back-to-back: a command may be accepted on the first IDLE cycle; there is no mandatory idle gap beyond ack=0.
- ack=1 in IDLE (stale or glitch): no command is accepted until ack=0; no response is generated.
- ack already high on the first REQ sample: treated as a valid ack.
- Response buffering: rsp_valid is not back-pressured; the consumer must take it in the pulse cycle.
- Reset mid-transaction: rq drops asynchronously to 0, no response is issued, and the in-flight command is lost.
- wr_ni is driven only from accepted commands and never changes while rq=1.

Decomposition:
- Shared package bus_pkg:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, REL=2'd2.
  - Constants WR_NI_READ=1'b1, WR_NI_WRITE=1'b0.
  - Default DATA_WIDTH/ADDR_WIDTH.
- Sub-module bus_timeout_cnt: clear/enable/limit inputs, expired output; reused by the arbiter.

Test Plan:
- Write: cmd addr=4'h3, data=8'hA5, wr_ni=0; client acks 1 cycle later → rq high for 2 cycles with address=3 and dataW=A5 stable; rsp_valid pulse with rsp_err=0; rsp_data unchanged.
- Read: cmd addr=4'hC, wr_ni=1; client drives dataR=8'h5E with ack → rsp_data=5E, rsp_err=0; rsp_valid exactly 1 cycle, at T+5 from acceptance.
- Timeout: TIMEOUT=16, client never acks → rq falls after 16 REQ cycles; rsp_valid with rsp_err=1; next command accepted normally.
- Back-to-back: two read commands held valid continuously → second accepted on the cycle rsp_valid of the first rises; no overlap of rq.
- Stale ack: hold ack=1 in IDLE with cmd_valid=1 → cmd_ready=0 and rq=0 until ack falls, then normal transaction.
- Reset mid-REQ: assert reset=0 while rq=1 → rq=0 immediately (asynchronous), no rsp_valid, all outputs at reset values.
